// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives all datapath enables and mux selects, including the 3-bit ALU code.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   opcode, funct     - instruction register fields instr[31:26], instr[5:0]
//   zero              - ALU zero flag, used to resolve beq
//   ALU_control       - ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
//   ALU_src_A/B       - ALU operand selects
//   PC_src            - PC source select (ALU result, ALUOut, jump target)
//   IorD              - memory address select (PC / ALUOut)
//   IR_write, mem_write, reg_write, pc_en - write enables
//   reg_dst, mem_to_reg - register file destination / data selects
//   state             - current state, for debug
// Outputs are a Moore decode of the state register (pc_en also looks at zero),
// so they settle in the same cycle the state is entered.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] ALU_control,
    output logic       ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic [1:0] PC_src,
    output logic       IorD,
    output logic       IR_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       pc_en,
    output logic [3:0] state
);

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    state_t state_q;
    state_t state_d;
    aluop_t alu_op;
    logic   pc_write;
    logic   branch;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode, ALU code decode and reset override
    always_comb begin
        alu_op      = ALUOP_ADD;
        pc_write    = 1'b0;
        branch      = 1'b0;
        ALU_control = 3'b010;
        ALU_src_A   = 1'b0;
        ALU_src_B   = 2'b00;
        PC_src      = 2'b00;
        IorD        = 1'b0;
        IR_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_en       = 1'b0;

        case (state_q)
            FETCH: begin
                IR_write  = 1'b1;
                pc_write  = 1'b1;
                ALU_src_B = 2'b01;
            end
            DECODE:  ALU_src_B = 2'b11;
            MEMADR, ADDIEX: begin
                ALU_src_A = 1'b1;
                ALU_src_B = 2'b10;
            end
            MEMRD:   IorD = 1'b1;
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                ALU_src_A = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BEQ: begin
                ALU_src_A = 1'b1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                PC_src    = 2'b01;
            end
            ADDIWB:  reg_write = 1'b1;
            JUMP: begin
                pc_write = 1'b1;
                PC_src   = 2'b10;
            end
            default: ;
        endcase

        case (alu_op)
            ALUOP_SUB: ALU_control = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    6'b100010: ALU_control = 3'b110;
                    6'b100100: ALU_control = 3'b000;
                    6'b100101: ALU_control = 3'b001;
                    6'b101010: ALU_control = 3'b111;
                    default:   ALU_control = 3'b010;
                endcase
            end
            default:   ALU_control = 3'b010;
        endcase

        pc_en = pc_write | (branch & zero);

        // Reset aborts the instruction: no write enables, selects park at FETCH values
        if (reset) begin
            ALU_control = 3'b010;
            ALU_src_A   = 1'b0;
            ALU_src_B   = 2'b01;
            PC_src      = 2'b00;
            IorD        = 1'b0;
            IR_write    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            pc_en       = 1'b0;
        end
    end

    assign state = 4'(state_q);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: a per-instruction step model
// predicts state and all outputs every cycle, and directed instruction runs pin
// state traces, ALU codes and enable counts to hand-computed values.
module tb_mips_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] ALU_control;
    logic       ALU_src_A;
    logic [1:0] ALU_src_B;
    logic [1:0] PC_src;
    logic       IorD;
    logic       IR_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_en;
    logic [3:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .ALU_control(ALU_control), .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B),
        .PC_src(PC_src), .IorD(IorD), .IR_write(IR_write), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .pc_en(pc_en), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // ---------------- model ----------------
    // Per-state output row; alu: 0 add, 1 sub, 2 from funct
    typedef struct packed {
        logic [1:0] alu;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       regdst;
        logic       m2r;
        logic       pcw;
        logic       br;
    } row_t;

    row_t tab [12];

    initial begin
        //           alu   A     B      pcsrc  iord irw  memw regw dst  m2r  pcw  br
        tab[0]  = {2'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[1]  = {2'd0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[2]  = {2'd0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[3]  = {2'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[4]  = {2'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[5]  = {2'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[6]  = {2'd2, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[7]  = {2'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[8]  = {2'd1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[9]  = {2'd0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[10] = {2'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[11] = {2'd0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    end

    // Cycles per instruction, counting FETCH
    function automatic int cpi(input logic [5:0] op);
        case (op)
            OP_LW:                   return 5;
            OP_SW, OP_R, OP_ADDI:    return 4;
            OP_BEQ, OP_J:            return 3;
            default:                 return 2;
        endcase
    endfunction

    // State visited at step p of an instruction
    function automatic int state_at(input logic [5:0] op, input int p);
        if (p == 0) return 0;
        if (p == 1) return 1;
        case (op)
            OP_LW:   return p;
            OP_SW:   return (p == 2) ? 2 : 5;
            OP_R:    return (p == 2) ? 6 : 7;
            OP_ADDI: return (p == 2) ? 9 : 10;
            OP_BEQ:  return 8;
            OP_J:    return 11;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    int         pos = 0;
    logic [5:0] cur_op = 6'd0;
    logic       valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            pos   <= 0;
            valid <= 1'b1;
        end else if (pos == 0) begin
            cur_op <= opcode;
            pos    <= 1;
        end else if (pos + 1 >= cpi(cur_op)) begin
            pos <= 0;
        end else begin
            pos <= pos + 1;
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (valid) begin
            int          es;
            row_t        r;
            logic [2:0]  ealu;
            logic [18:0] expv;
            logic [18:0] actv;
            es = state_at(cur_op, pos);
            r  = tab[es];
            ealu = (r.alu == 2'd1) ? 3'b110 : ((r.alu == 2'd2) ? alu_of_funct(funct) : 3'b010);
            if (reset)
                expv = {3'b010, 1'b0, 2'b01, 2'b00, 7'b0, 4'(es)};
            else
                expv = {ealu, r.src_a, r.src_b, r.pc_src, r.iord, r.irw, r.memw, r.regw,
                        r.regdst, r.m2r, r.pcw | (r.br & zero), 4'(es)};
            actv = {ALU_control, ALU_src_A, ALU_src_B, PC_src, IorD, IR_write, mem_write,
                    reg_write, reg_dst, mem_to_reg, pc_en, state};
            n_chk++;
            if (actv !== expv) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got=%b want=%b (alu,A,B,pcsrc,iord,irw,memw,regw,dst,m2r,pcen,state)",
                         $time, actv, expv);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH; entry and exit at posedge+1 in FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int ncyc, output logic [19:0] sig,
                             output logic [2:0] ex_alu, output logic br_pc,
                             output int regw_cnt, output int memw_cnt);
        opcode = op;
        funct  = fn;
        zero   = z;
        sig = '0;
        ex_alu = 3'b000;
        br_pc = 1'b0;
        regw_cnt = 0;
        memw_cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            sig = {sig[15:0], state};
            if (state == 4'd6) ex_alu = ALU_control;
            if (state == 4'd8) br_pc = pc_en;
            regw_cnt += int'(reg_write);
            memw_cnt += int'(mem_write);
            @(posedge clk);
            #1;
        end
    endtask

    logic [19:0] sig;
    logic [2:0]  ex_alu;
    logic        br_pc;
    int          rw;
    int          mw;
    logic [5:0]  fn_tab [5];
    logic [2:0]  alu_exp [5];

    initial begin
        reset  = 1'b1;
        opcode = OP_R;
        funct  = 6'b100000;
        zero   = 1'b0;
        fn_tab[0] = 6'b100010; alu_exp[0] = 3'b110;
        fn_tab[1] = 6'b100100; alu_exp[1] = 3'b000;
        fn_tab[2] = 6'b100101; alu_exp[2] = 3'b001;
        fn_tab[3] = 6'b101010; alu_exp[3] = 3'b111;
        fn_tab[4] = 6'b111111; alu_exp[4] = 3'b010;

        // Reset held three edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_pc_en", 32'(pc_en), 32'd0);
        chk("reset_ir_write", 32'(IR_write), 32'd0);
        chk("reset_alu_src_b", 32'(ALU_src_B), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_pc_en", 32'(pc_en), 32'd1);
        chk("post_reset_ir_write", 32'(IR_write), 32'd1);
        chk("post_reset_alu", 32'(ALU_control), 32'b010);
        // Finish the R-type add that was fetched
        repeat (4) @(posedge clk);
        #1;

        run_instr(OP_LW, 6'd0, 1'b0, 5, sig, ex_alu, br_pc, rw, mw);
        chk("lw_trace", 32'(sig), 32'h01234);
        chk("lw_regw_count", 32'(rw), 32'd1);
        chk("lw_memw_count", 32'(mw), 32'd0);

        for (int k = 0; k < 5; k++) begin
            run_instr(OP_R, fn_tab[k], 1'b0, 4, sig, ex_alu, br_pc, rw, mw);
            chk("rtype_trace", 32'(sig), 32'h00167);
            chk("rtype_exec_alu", 32'(ex_alu), 32'(alu_exp[k]));
            chk("rtype_regw_count", 32'(rw), 32'd1);
        end

        run_instr(OP_BEQ, 6'd0, 1'b1, 3, sig, ex_alu, br_pc, rw, mw);
        chk("beq_taken_trace", 32'(sig), 32'h00018);
        chk("beq_taken_pc_en", 32'(br_pc), 32'd1);
        run_instr(OP_BEQ, 6'd0, 1'b0, 3, sig, ex_alu, br_pc, rw, mw);
        chk("beq_not_taken_pc_en", 32'(br_pc), 32'd0);
        zero = 1'b0;

        run_instr(OP_SW, 6'd0, 1'b0, 4, sig, ex_alu, br_pc, rw, mw);
        chk("sw_trace", 32'(sig), 32'h00125);
        chk("sw_memw_count", 32'(mw), 32'd1);
        chk("sw_regw_count", 32'(rw), 32'd0);

        run_instr(OP_ADDI, 6'd0, 1'b0, 4, sig, ex_alu, br_pc, rw, mw);
        chk("addi_trace", 32'(sig), 32'h0019A);
        chk("addi_regw_count", 32'(rw), 32'd1);

        run_instr(OP_J, 6'd0, 1'b0, 3, sig, ex_alu, br_pc, rw, mw);
        chk("j_trace", 32'(sig), 32'h0001B);

        run_instr(6'b111111, 6'd0, 1'b0, 2, sig, ex_alu, br_pc, rw, mw);
        chk("illegal_trace", 32'(sig), 32'h00001);

        // j aborted by reset in DECODE
        opcode = OP_J;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_decode_state", 32'(state), 32'd1);
        chk("abort_pc_en", 32'(pc_en), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_next_state", 32'(state), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_abort_fetch", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
